// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file exported to fabric logic.
// SCL/SDA are synchronized, filtered and edge-detected on clk_i; SDA is only ever pulled low.
module i2c_target_regfile #(
    parameter logic [6:0] Addr        = 7'h50,
    parameter int         NumRegs     = 16,
    parameter int         FilterDepth = 3,
    localparam int        PtrW        = $clog2(NumRegs)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   scl_i,
    input  logic                   sda_i,
    output logic                   sda_oe_o,
    output logic                   busy_o,
    output logic                   wr_valid_o,
    output logic [PtrW-1:0]        wr_addr_o,
    output logic [7:0]             wr_data_o,
    output logic [NumRegs*8-1:0]   regs_o
);

    localparam int FcW = (FilterDepth > 1) ? $clog2(FilterDepth) : 1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_PTR      = 4'd3,
        ST_DATA_W   = 4'd4,
        ST_W_ACK    = 4'd5,
        ST_DATA_R   = 4'd6,
        ST_R_ACK    = 4'd7,
        ST_WAIT     = 4'd8
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA.
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_filt;
    logic [1:0]      r_filt_d;
    logic [FcW-1:0]  r_fcnt [2];

    state_t          r_state;
    logic [3:0]      r_bitcnt;
    logic [6:0]      r_shift;
    logic [6:0]      r_tx;
    logic            r_rw;
    logic [PtrW-1:0] r_ptr;
    logic            r_sda_oe;
    logic            r_busy;
    logic            r_wr_valid;
    logic [PtrW-1:0] r_wr_addr;
    logic [7:0]      r_wr_data;
    logic [7:0]      r_regs [NumRegs];

    logic            w_scl_rise;
    logic            w_scl_fall;
    logic            w_start;
    logic            w_stop;
    logic [7:0]      w_byte;
    logic            w_last_bit;
    logic [7:0]      w_rd_byte;

    // Synchronize both pads, then let a line change only after FilterDepth stable cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                r_fcnt[i] <= '0;
            end
        end else begin
            r_sync1  <= {sda_i, scl_i};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FcW'(FilterDepth - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    // START/STOP need SCL high on both sides of the SDA edge, so an SCL edge always wins.
    assign w_scl_rise = r_filt[0] & ~r_filt_d[0];
    assign w_scl_fall = ~r_filt[0] & r_filt_d[0];
    assign w_start    = r_filt[0] & r_filt_d[0] & ~r_filt[1] & r_filt_d[1];
    assign w_stop     = r_filt[0] & r_filt_d[0] & r_filt[1] & ~r_filt_d[1];
    assign w_byte     = {r_shift, r_filt[1]};
    assign w_last_bit = (r_bitcnt == 4'd7);
    assign w_rd_byte  = r_regs[r_ptr];

    // Protocol FSM: bits are captured on SCL rise, SDA drive changes only on SCL fall.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= 4'd0;
            r_shift    <= 7'd0;
            r_tx       <= 7'd0;
            r_rw       <= 1'b0;
            r_ptr      <= '0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'd0;
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= 8'd0;
            end
        end else begin
            r_wr_valid <= 1'b0;
            if (w_start) begin
                r_state  <= ST_ADDR;
                r_bitcnt <= 4'd0;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_last_bit) begin
                                if (w_byte[7:1] == Addr) begin
                                    r_state <= ST_ADDR_ACK;
                                    r_rw    <= w_byte[0];
                                    r_busy  <= 1'b1;
                                end else begin
                                    r_state <= ST_WAIT;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        // First fall starts the ACK, second fall ends it and begins the data phase.
                        if (w_scl_fall) begin
                            r_bitcnt <= 4'd0;
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else if (r_rw) begin
                                r_state  <= ST_DATA_R;
                                r_tx     <= w_rd_byte[6:0];
                                r_sda_oe <= ~w_rd_byte[7];
                            end else begin
                                r_state  <= ST_PTR;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_PTR, ST_DATA_W: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_last_bit) begin
                                r_state <= ST_W_ACK;
                                if (r_state == ST_PTR) begin
                                    r_ptr <= w_byte[PtrW-1:0];
                                end else begin
                                    r_regs[r_ptr] <= w_byte;
                                    r_wr_valid    <= 1'b1;
                                    r_wr_addr     <= r_ptr;
                                    r_wr_data     <= w_byte;
                                    r_ptr         <= r_ptr + 1'b1;
                                end
                            end
                        end
                    end
                    ST_W_ACK: begin
                        if (w_scl_fall) begin
                            r_bitcnt <= 4'd0;
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_state  <= ST_DATA_W;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_DATA_R: begin
                        // A zero bit count on a fall means a new byte follows a host ACK.
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd0) begin
                                r_tx     <= w_rd_byte[6:0];
                                r_sda_oe <= ~w_rd_byte[7];
                            end else if (r_bitcnt == 4'd8) begin
                                r_state  <= ST_R_ACK;
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_tx     <= {r_tx[5:0], 1'b0};
                                r_sda_oe <= ~r_tx[6];
                            end
                        end
                    end
                    ST_R_ACK: begin
                        if (w_scl_rise) begin
                            if (!r_filt[1]) begin
                                r_state  <= ST_DATA_R;
                                r_bitcnt <= 4'd0;
                                r_ptr    <= r_ptr + 1'b1;
                            end else begin
                                r_state <= ST_WAIT;
                            end
                        end
                    end
                    ST_IDLE, ST_WAIT: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe_o   = r_sda_oe;
    assign busy_o     = r_busy;
    assign wr_valid_o = r_wr_valid;
    assign wr_addr_o  = r_wr_addr;
    assign wr_data_o  = r_wr_data;

    for (genvar g = 0; g < NumRegs; g++) begin : g_regs_out
        assign regs_o[8*g +: 8] = r_regs[g];
    end

endmodule
